crossbar_ingress_port: RTL

Source-side agent for one crossbar input port. It accepts {dest, data} words from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to the crossbar as req/dest/data and holds that head stable until the crossbar returns grant. One instance sits in front of each crossbar input; it also reports starvation and a count of sent words.

---
 rtl/xbar_pkg.sv | 20 ++
 rtl/crossbar_ingress_port_if.sv | 25 ++
 rtl/crossbar_ingress_fifo.sv | 53 +++++
 rtl/crossbar_ingress_port.sv | 95 +++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared types for the crossbar ingress agent.
// Word width, destination width, queued-word bundle and FSM states.
package xbar_pkg;

    localparam int DW    = 32;
    localparam int M     = 4;
    localparam int DESTW = $clog2(M);

    typedef struct packed {
        logic [DESTW-1:0] dest;
        logic [DW-1:0]    data;
    } xbar_word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        STARVED
    } ingress_state_t;

endpackage

// File: rtl/crossbar_ingress_port_if.sv
// Upstream valid/ready bundle plus the crossbar req/grant bundle.
// slave: the ingress agent view; master: producer/crossbar view.
interface crossbar_ingress_port_if;
    import xbar_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DESTW-1:0] in_dest;
    logic [DW-1:0]    in_data;
    logic             req;
    logic [DESTW-1:0] dest;
    logic [DW-1:0]    data_out;
    logic             grant;

    modport slave (
        input  in_valid, in_dest, in_data, grant,
        output in_ready, req, dest, data_out
    );

    modport master (
        output in_valid, in_dest, in_data, grant,
        input  in_ready, req, dest, data_out
    );

endinterface

// File: rtl/crossbar_ingress_fifo.sv
// Synchronous FIFO of xbar_word_t with push/pop/flush.
// Ports: push/wr_word in, pop in, head/full/empty/count out.
module crossbar_ingress_fifo
    import xbar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  xbar_word_t             wr_word,
    input  logic                   pop,
    output xbar_word_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    xbar_word_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra wrap bit separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr[AW-1:0]] <= wr_word;
    end

endmodule

// File: rtl/crossbar_ingress_port.sv
// Ingress agent for one crossbar input: buffers words, requests.
// Ports: clk, rst (sync, low), flush, xif, starve, sent_cnt.
module crossbar_ingress_port
    import xbar_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    crossbar_ingress_port_if.slave        xif,
    output logic                          starve,
    output logic [15:0]                   sent_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [7:0]    WMAX = 8'(MAX_WAIT);
    localparam logic [7:0]    WPRE = 8'(MAX_WAIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    ingress_state_t state_q;
    ingress_state_t state_d;
    xbar_word_t     wr_word;
    xbar_word_t     head;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;
    logic [7:0]     wait_q;
    logic           push;
    logic           pop;
    logic           last;

    assign xif.in_ready = !full && !flush;
    assign push         = xif.in_valid && xif.in_ready;
    assign xif.req      = !empty;
    // Flush wins over grant: no pop, no count.
    assign pop          = xif.req && xif.grant && !flush;
    assign wr_word      = '{dest: xif.in_dest, data: xif.in_data};
    assign xif.dest     = head.dest;
    assign xif.data_out = head.data;
    assign last         = (count == ONE) && !push;
    assign starve       = (state_q == STARVED);

    crossbar_ingress_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .wr_word (wr_word),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            sent_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (flush || pop) begin
                wait_q <= '0;
            end else if (xif.req && wait_q != WMAX) begin
                wait_q <= wait_q + 8'd1;
            end
            if (pop) sent_cnt <= sent_cnt + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = REQUEST;
            end
            REQUEST: begin
                if (pop) begin
                    if (last) state_d = IDLE;
                end else if (wait_q == WPRE) begin
                    state_d = STARVED;
                end
            end
            STARVED: begin
                if (pop) state_d = last ? IDLE : REQUEST;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

endmodule
